// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
// Module   : cp0
// Purpose  : Coprocessor-0 exception and interrupt unit. Holds SR, Cause, EPC
//            and PRId, combines masked device interrupts with the pipeline's
//            internal exception code into a single flush/vector request, and
//            records the return context (EPC, BD, ExcCode) when it fires.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1   pipeline clock, all state updates on posedge
//   reset    in   1   asynchronous, active-low; clears all state
//   A1       in   5   mfc0 read register select
//   A2       in   5   mtc0 write register select
//   DIn      in  32   mtc0 write data
//   WE       in   1   mtc0 write enable
//   PC       in  32   PC of the instruction in the exception-commit stage
//   BD       in   1   that instruction sits in a branch delay slot
//   ExcCode  in   5   internal exception code, 0 = none
//   HWInt    in   6   level-sensitive device interrupt lines
//   EXLClr   in   1   eret committing
//   Req      out  1   take exception/interrupt this cycle
//   EPC      out 32   current EPC for the eret redirect
//   DOut     out 32   mfc0 read data
// ============================================================================
module cp0 #(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] C_REG_SR    = 5'd12;
    localparam logic [4:0] C_REG_CAUSE = 5'd13;
    localparam logic [4:0] C_REG_EPC   = 5'd14;
    localparam logic [4:0] C_REG_PRID  = 5'd15;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [5:0]  im_q,      im_d;       // SR.IM
    logic        exl_q,     exl_d;      // SR.EXL
    logic        ie_q,      ie_d;       // SR.IE
    logic        bd_q,      bd_d;       // Cause.BD
    logic [5:0]  ip_q,      ip_d;       // Cause.IP
    logic [4:0]  exccode_q, exccode_d;  // Cause.ExcCode
    logic [29:0] epc_q,     epc_d;      // EPC[31:2]

    // ------------------------------------------------------------------
    // Request logic
    // ------------------------------------------------------------------
    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_ret_pc;
    logic        unused_ret_pc_lo;

    assign w_int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign w_exc_req = (ExcCode != 5'd0) & ~exl_q;
    assign Req       = w_int_req | w_exc_req;

    // A delay-slot instruction must resume at its branch, one word earlier.
    assign w_ret_pc         = BD ? (PC - 32'd4) : PC;
    assign unused_ret_pc_lo = ^w_ret_pc[1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        // Pending bits track the raw lines every cycle, unmasked.
        ip_d      = HWInt;

        if (Req) begin
            // The committing instruction is flushed, so any mtc0 it carries
            // is dropped rather than merged with the exception update.
            exl_d     = 1'b1;
            bd_d      = BD;
            epc_d     = w_ret_pc[31:2];
            exccode_d = w_int_req ? 5'd0 : ExcCode;
        end else begin
            if (WE && (A2 == C_REG_SR)) begin
                im_d  = DIn[15:10];
                exl_d = DIn[1];
                ie_d  = DIn[0];
            end
            if (WE && (A2 == C_REG_EPC)) begin
                epc_d = DIn[31:2];
            end
            // eret beats a simultaneous SR write for the EXL bit only.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    // ------------------------------------------------------------------
    // Read side (no write bypass: a same-cycle read sees the old value)
    // ------------------------------------------------------------------
    logic [31:0] w_sr_word;
    logic [31:0] w_cause_word;

    assign w_sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign w_cause_word = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
    assign EPC          = {epc_q, 2'b00};

    always_comb begin
        DOut = 32'd0;
        case (A1)
            C_REG_SR:    DOut = w_sr_word;
            C_REG_CAUSE: DOut = w_cause_word;
            C_REG_EPC:   DOut = EPC;
            C_REG_PRID:  DOut = PRID;
            default:     DOut = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0
// Purpose  : Scoreboard bench for cp0. Stimulus drives inputs once per
//            cycle and pushes the expected Req/EPC/DOut computed from a
//            word-level register model; a monitor pops and compares on the
//            falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCode;
    logic [31:0] DIn, PC;
    logic        WE, BD, EXLClr;
    logic [5:0]  HWInt;
    wire         Req;
    wire  [31:0] EPC, DOut;

    always #5 clk = ~clk;

    cp0 dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
        .Req(Req), .EPC(EPC), .DOut(DOut)
    );

    typedef struct {
        logic        req;
        logic [31:0] epc;
        logic [31:0] dout;
        logic [4:0]  a1;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: whole 32-bit register images.
    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h4D49_5053;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((ExcCode != 5'd0) && !m_sr[1]);
    endfunction

    task automatic m_clear();
        m_sr = 0; m_cause = 0; m_epc = 0;
    endtask

    // Apply the registered effect of one rising edge to the model.
    task automatic m_edge();
        logic [31:0] nsr, ncause, nepc;
        if (!reset) begin
            m_clear();
            return;
        end
        nsr = m_sr; ncause = m_cause; nepc = m_epc;
        if (m_req()) begin
            nsr[1]       = 1'b1;
            ncause[31]   = BD;
            nepc         = (BD ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
            ncause[6:2]  = m_int() ? 5'd0 : ExcCode;
        end else begin
            if (WE && A2 == 5'd12) nsr = DIn & 32'h0000_FC03;
            if (WE && A2 == 5'd14) nepc = DIn & 32'hFFFF_FFFC;
            if (EXLClr) nsr[1] = 1'b0;
        end
        ncause[15:10] = HWInt;
        m_sr = nsr; m_cause = ncause; m_epc = nepc;
    endtask

    // Drive one cycle of inputs (called at posedge+1), queue the expected
    // combinational outputs, then advance to the next posedge+1.
    task automatic apply(input logic [4:0] a1, input logic [4:0] a2,
                         input logic we, input logic [31:0] din,
                         input logic [31:0] pc, input logic bd,
                         input logic [4:0] exc, input logic [5:0] hw,
                         input logic clr);
        exp_t e;
        A1 = a1; A2 = a2; WE = we; DIn = din; PC = pc; BD = bd;
        ExcCode = exc; HWInt = hw; EXLClr = clr;
        if (!reset) m_clear();
        e.req  = m_req();
        e.epc  = m_epc;
        e.dout = m_read(a1);
        e.a1   = a1;
        sb.push_back(e);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // Shorthands for the directed section.
    task automatic idle(input logic [4:0] a1, input logic [5:0] hw);
        apply(a1, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, hw, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a2, input logic [31:0] din);
        apply(5'd12, a2, 1'b1, din, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
    endtask

    task automatic eret();
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1);
    endtask

    // Monitor: compare whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (Req !== e.req) begin
                bad++;
                $display("FAIL req t=%0t got=%0b exp=%0b", $time, Req, e.req);
            end
            total++;
            if (EPC !== e.epc) begin
                bad++;
                $display("FAIL epc t=%0t got=%08h exp=%08h", $time, EPC, e.epc);
            end
            total++;
            if (DOut !== e.dout) begin
                bad++;
                $display("FAIL dout(a1=%0d) t=%0t got=%08h exp=%08h",
                         e.a1, $time, DOut, e.dout);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] regs[6];
        regs[0] = 5'd12; regs[1] = 5'd13; regs[2] = 5'd14;
        regs[3] = 5'd15; regs[4] = 5'd0;  regs[5] = 5'd31;

        A1 = 0; A2 = 0; WE = 0; DIn = 0; PC = 0; BD = 0;
        ExcCode = 0; HWInt = 0; EXLClr = 0;
        m_clear();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state of every readable register.
        idle(5'd12, 6'h00);
        idle(5'd13, 6'h00);
        idle(5'd14, 6'h00);
        reset = 1'b1;
        idle(5'd15, 6'h00);

        // Exception to get EXL=1, EPC=3008, then reset mid-run.
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h3008, 1'b0, 5'd3, 6'h00, 1'b0);
        idle(5'd14, 6'h00);
        reset = 1'b0;
        idle(5'd12, 6'h00);
        reset = 1'b1;
        idle(5'd12, 6'h01);

        // Enabled timer interrupt.
        wr(5'd12, 32'h0000_0401);
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h3010, 1'b0, 5'd0, 6'h01, 1'b0);
        idle(5'd13, 6'h01);
        idle(5'd12, 6'h01);
        eret();

        // Masked vs unmasked line.
        wr(5'd12, 32'h0000_0801);
        idle(5'd13, 6'h01);
        idle(5'd13, 6'h01);
        idle(5'd13, 6'h02);
        idle(5'd13, 6'h00);
        eret();

        // Internal exception in a delay slot, then dropped during EXL.
        wr(5'd12, 32'h0);
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h3020, 1'b1, 5'd10, 6'h00, 1'b0);
        idle(5'd14, 6'h00);
        apply(5'd13, 5'd0, 1'b0, 32'h0, 32'h3024, 1'b0, 5'd4, 6'h00, 1'b0);
        idle(5'd12, 6'h00);
        eret();

        // Delay slot at PC=0 wraps.
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd8, 6'h00, 1'b0);
        idle(5'd14, 6'h00);
        eret();

        // Interrupt + exception + mtc0 EPC in one cycle.
        wr(5'd12, 32'h0000_0401);
        apply(5'd14, 5'd14, 1'b1, 32'hDEAD_BEEF, 32'h3040, 1'b0, 5'd12,
              6'h01, 1'b0);
        idle(5'd13, 6'h00);
        idle(5'd14, 6'h00);
        eret();

        // Held IRQ re-raises right after eret; SR write + EXLClr.
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h3050, 1'b0, 5'd0, 6'h01, 1'b0);
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h3054, 1'b0, 5'd0, 6'h01, 1'b1);
        apply(5'd12, 5'd0, 1'b0, 32'h0, 32'h3058, 1'b0, 5'd0, 6'h01, 1'b0);
        apply(5'd12, 5'd12, 1'b1, 32'h0000_0403, 32'h0, 1'b0, 5'd0, 6'h00,
              1'b1);
        idle(5'd12, 6'h00);
        wr(5'd14, 32'h1234_5677);
        idle(5'd14, 6'h00);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [4:0]  a1, a2, exc;
            logic [5:0]  hw;
            logic        we, clr;
            a1  = regs[$urandom_range(0, 5)];
            a2  = regs[$urandom_range(0, 5)];
            we  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 5) == 0);
            exc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            if (i == 300) reset = 1'b0;
            if (i == 302) reset = 1'b1;
            apply(a1, a2, we, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  1'($urandom), exc, hw, clr);
        end

        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
